fnn_layer_sequencer: RTL and testbench

Sequences a 4-layer, 4-neuron-per-layer feed-forward inference through one shared external multiply-accumulate engine. The block accepts a packed 4×8-bit input vector and drives weight addresses and MAC controls neuron by neuron. It requantizes each accumulator result (shift, ReLU, saturate) into ping-pong activation buffers and returns the packed 4×8-bit output vector over a valid/ready handshake. It sits between the FNN top-level stream interface and the MAC/weight-ROM datapath.

---
 rtl/fnn_pkg.sv | 22 ++
 rtl/fnn_layer_sequencer_if.sv | 27 ++
 rtl/fnn_requant.sv | 28 ++
 rtl/fnn_layer_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_fnn_layer_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fnn_pkg.sv
// rtl/fnn_pkg.sv - shared state type and sizing constants for the FNN layer sequencer
package fnn_pkg;

  localparam int N_LAYERS  = 4;
  localparam int N_NEURONS = 4;
  localparam int DATA_W    = 8;
  localparam int ACC_W     = 20;
  localparam int SHIFT     = 4;
  localparam int W_ADDR_W  = 6;
  localparam int LAYER_W   = $clog2(N_LAYERS);
  localparam int NEURON_W  = $clog2(N_NEURONS);
  localparam int VEC_W     = N_NEURONS * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_WB,
    S_OUT
  } fnn_state_e;

endpackage

// File: rtl/fnn_layer_sequencer_if.sv
// rtl/fnn_layer_sequencer_if.sv - vector stream handshakes plus MAC/weight-ROM control bus
interface fnn_layer_sequencer_if;
  import fnn_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [VEC_W-1:0]         in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [VEC_W-1:0]         out_data;
  logic [W_ADDR_W-1:0]      w_addr;
  logic                     mac_clr;
  logic                     mac_en;
  logic [DATA_W-1:0]        mac_a;
  logic signed [ACC_W-1:0]  mac_acc;

  modport master (
    output in_valid, in_data, out_ready, mac_acc,
    input  in_ready, out_valid, out_data, w_addr, mac_clr, mac_en, mac_a
  );

  modport slave (
    input  in_valid, in_data, out_ready, mac_acc,
    output in_ready, out_valid, out_data, w_addr, mac_clr, mac_en, mac_a
  );

endinterface

// File: rtl/fnn_requant.sv
// rtl/fnn_requant.sv - combinational accumulator requantizer: arithmetic shift, ReLU, saturate
module fnn_requant
  import fnn_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int SHIFT_AMT  = SHIFT
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic        [DATA_WIDTH-1:0] q_o
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** DATA_WIDTH - 1);

  logic signed [ACC_WIDTH-1:0] shifted;

  assign shifted = acc_i >>> SHIFT_AMT;

  always_comb begin
    q_o = shifted[DATA_WIDTH-1:0];
    if (shifted < 0) begin
      q_o = '0;
    end else if (shifted > SAT_MAX) begin
      q_o = '1;
    end
  end

endmodule

// File: rtl/fnn_layer_sequencer.sv
// rtl/fnn_layer_sequencer.sv - 4x4 FNN inference sequencer over a shared MAC, ping-pong activations
// Optional FNN_SEQ_PERF_EN adds the perf_cycles latency counter output.
module fnn_layer_sequencer
  import fnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  fnn_layer_sequencer_if.slave bus,
  output logic                 busy,
  output logic [LAYER_W-1:0]   layer_idx,
  output logic [NEURON_W-1:0]  neuron_idx
`ifdef FNN_SEQ_PERF_EN
  ,
  output logic [15:0]          perf_cycles
`endif
);

  localparam logic [LAYER_W-1:0]  LAYER_LAST  = LAYER_W'(N_LAYERS - 1);
  localparam logic [NEURON_W-1:0] NEURON_LAST = NEURON_W'(N_NEURONS - 1);

  fnn_state_e          state_q, state_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic [NEURON_W-1:0] neuron_q, neuron_d;
  logic [NEURON_W-1:0] k_q, k_d;
  logic                src_sel_q, src_sel_d;
  logic [DATA_W-1:0]   buf_a_q [N_NEURONS];
  logic [DATA_W-1:0]   buf_a_d [N_NEURONS];
  logic [DATA_W-1:0]   buf_b_q [N_NEURONS];
  logic [DATA_W-1:0]   buf_b_d [N_NEURONS];
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [VEC_W-1:0]    out_data_q, out_data_d;
  logic                busy_q, busy_d;
  logic                mac_clr_q, mac_clr_d;
  logic                mac_en_q, mac_en_d;
  logic [DATA_W-1:0]   mac_a_q, mac_a_d;
  logic [W_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   wb_val;
  logic                accept;
  logic                handshake;

  assign accept    = (state_q == S_IDLE) && bus.in_valid && in_ready_q;
  assign handshake = (state_q == S_OUT) && out_valid_q && bus.out_ready;

  fnn_requant #(
    .ACC_WIDTH (ACC_W),
    .DATA_WIDTH(DATA_W),
    .SHIFT_AMT (SHIFT)
  ) u_requant (
    .acc_i(bus.mac_acc),
    .q_o  (wb_val)
  );

  // src_sel_q=0: A is the source layer, B receives write-backs; swapped after each layer.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    neuron_d    = neuron_q;
    k_d         = k_q;
    src_sel_d   = src_sel_q;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int i = 0; i < N_NEURONS; i++) begin
            buf_a_d[i] = bus.in_data[i*DATA_W +: DATA_W];
          end
          layer_d   = '0;
          neuron_d  = '0;
          k_d       = '0;
          src_sel_d = 1'b0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (k_q == NEURON_LAST) begin
          state_d = S_WB;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_WB: begin
        if (src_sel_q) begin
          buf_a_d[neuron_q] = wb_val;
        end else begin
          buf_b_d[neuron_q] = wb_val;
        end
        if (neuron_q != NEURON_LAST) begin
          neuron_d = neuron_q + 1'b1;
          state_d  = S_CLEAR;
        end else begin
          neuron_d  = '0;
          src_sel_d = ~src_sel_q;
          if (layer_q != LAYER_LAST) begin
            layer_d = layer_q + 1'b1;
            state_d = S_CLEAR;
          end else begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        // First OUT cycle loads the result; it then holds until the consumer takes it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          for (int i = 0; i < N_NEURONS; i++) begin
            out_data_d[i*DATA_W +: DATA_W] = src_sel_q ? buf_b_q[i] : buf_a_q[i];
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    mac_clr_d  = (state_d == S_CLEAR);
    mac_en_d   = (state_d == S_MAC);
    w_addr_d   = mac_en_d ? {layer_d, neuron_d, k_d} : '0;
    mac_a_d    = '0;
    if (mac_en_d) begin
      mac_a_d = src_sel_q ? buf_b_q[k_d] : buf_a_q[k_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      neuron_q    <= '0;
      k_q         <= '0;
      src_sel_q   <= 1'b0;
      buf_a_q     <= '{default: '0};
      buf_b_q     <= '{default: '0};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      w_addr_q    <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      neuron_q    <= neuron_d;
      k_q         <= k_d;
      src_sel_q   <= src_sel_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      w_addr_q    <= w_addr_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.w_addr    = w_addr_q;
  assign busy          = busy_q;
  assign layer_idx     = layer_q;
  assign neuron_idx    = neuron_q;

`ifdef FNN_SEQ_PERF_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] perf_q, perf_d;

  always_comb begin
    cnt_d  = cnt_q;
    perf_d = perf_q;
    if (accept) begin
      cnt_d = '0;
    end else if (handshake) begin
      perf_d = cnt_q;
    end else if (state_q != S_IDLE) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_fnn_layer_sequencer.sv
// tb/tb_fnn_layer_sequencer.sv - directed self-checking bench with a behavioural 1-cycle MAC
module tb_fnn_layer_sequencer;
  import fnn_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                busy;
  logic [LAYER_W-1:0]  layer_idx;
  logic [NEURON_W-1:0] neuron_idx;
`ifdef FNN_SEQ_PERF_EN
  logic [15:0]         perf_cycles;
`endif

  fnn_layer_sequencer_if bus();

  fnn_layer_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .layer_idx (layer_idx),
`ifdef FNN_SEQ_PERF_EN
    .neuron_idx(neuron_idx),
    .perf_cycles(perf_cycles)
`else
    .neuron_idx(neuron_idx)
`endif
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  int acc_edge = 0;
  int checks   = 0;
  int failures = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic signed [7:0]        wmem [64];
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  a_ext;
  logic signed [ACC_W-1:0]  w_ext;

  assign a_ext       = {{(ACC_W-DATA_W){1'b0}}, bus.mac_a};
  assign w_ext       = ACC_W'(wmem[bus.w_addr]);
  assign bus.mac_acc = acc_r;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_r <= '0;
    else if (bus.mac_clr) acc_r <= '0;
    else if (bus.mac_en) acc_r <= acc_r + a_ext * w_ext;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_const(input logic signed [7:0] w);
    for (int i = 0; i < 64; i++) wmem[i] = w;
  endtask

  task automatic set_identity();
    for (int l = 0; l < 4; l++)
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 4; k++)
          wmem[l*16 + n*4 + k] = (n == k) ? 8'sd16 : 8'sd0;
  endtask

  task automatic start_inference(input string tag, input logic [31:0] v);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clk);
    acc_edge     = edge_cnt;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_out(input string tag);
    bit seen = 0;
    bit busy_ok = 1;
    bit rdy_ok = 1;
    int lat = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (!busy) busy_ok = 0;
      if (bus.in_ready) rdy_ok = 0;
      if (bus.out_valid) begin
        seen = 1;
        lat  = edge_cnt - acc_edge;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_busy_high"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_in_ready_low"}, {31'd0, rdy_ok}, 32'd1);
    check({tag, "_out_latency"}, lat, 32'd97);
  endtask

  task automatic complete(input string tag, input logic [31:0] exp, input int exp_perf);
    check({tag, "_out_data"}, bus.out_data, exp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_hs"}, {29'd0, bus.out_valid, bus.in_ready, busy}, {29'd0, 3'b010});
`ifdef FNN_SEQ_PERF_EN
    check({tag, "_perf_cycles"}, {16'd0, perf_cycles}, exp_perf);
`else
    if (exp_perf < 0) $display("note: negative perf expectation ignored");
`endif
  endtask

  initial begin
    logic [31:0] stall_ok;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    set_identity();

    repeat (3) @(negedge clk);
    check("reset_ctrl", {19'd0, bus.in_ready, bus.out_valid, busy, bus.mac_clr, bus.mac_en,
                         bus.w_addr, layer_idx, neuron_idx}, 32'd0);
    check("reset_mac_a", {24'd0, bus.mac_a}, 32'd0);
    check("reset_out_data", bus.out_data, 32'd0);
`ifdef FNN_SEQ_PERF_EN
    check("reset_perf", {16'd0, perf_cycles}, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // identity, with a look at the first neuron's control sequence
    start_inference("ident", 32'h01020304);
    check("clear_cycle", {30'd0, bus.mac_clr, bus.mac_en}, 32'd2);
    @(negedge clk);
    check("mac_k0", {23'd0, bus.mac_en, bus.w_addr, 2'd0}, {23'd0, 1'b1, 6'd0, 2'd0});
    check("mac_a_k0", {24'd0, bus.mac_a}, 32'h04);
    @(negedge clk);
    check("mac_k1", {24'd0, bus.mac_a}, 32'h03);
    check("w_addr_k1", {26'd0, bus.w_addr}, 32'd1);
    repeat (2) @(negedge clk);
    check("mac_k3", {18'd0, bus.w_addr, bus.mac_a}, {18'd0, 6'd3, 8'h01});
    @(negedge clk);
    check("wb_mac_idle", {23'd0, bus.mac_en, bus.mac_a}, 32'd0);
    @(negedge clk);
    check("n1_clear", {29'd0, bus.mac_clr, neuron_idx}, {29'd0, 1'b1, 2'd1});
    @(negedge clk);
    check("n1_w_addr", {26'd0, bus.w_addr}, 32'd4);
    wait_out("ident");
    check("final_idx", {28'd0, layer_idx, neuron_idx}, {28'd0, 2'd3, 2'd0});
    complete("ident", 32'h01020304, 97);

    // layer 0 doubles, layer 1 rotates: in [4,3,2,1] -> [8,6,4,2] -> [6,4,2,8]
    set_identity();
    for (int n = 0; n < 4; n++) wmem[n*4 + n] = 8'sd32;
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++)
        wmem[16 + n*4 + k] = (k == ((n + 1) % 4)) ? 8'sd16 : 8'sd0;
    start_inference("mixed", 32'h01020304);
    wait_out("mixed");
    complete("mixed", 32'h08020406, 97);

    set_const(-8'sd1);
    start_inference("relu", 32'h05060708);
    wait_out("relu");
    complete("relu", 32'h00000000, 97);

    set_const(8'sd127);
    start_inference("sat", 32'hFFFFFFFF);
    wait_out("sat");
    complete("sat", 32'hFFFFFFFF, 97);

    // consumer stalls 20 cycles while a second vector is offered
    set_identity();
    start_inference("stall", 32'h0A0B0C0D);
    wait_out("stall");
    stall_ok = 32'd1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 32'h11111111;
      @(negedge clk);
      if (bus.out_data !== 32'h0A0B0C0D || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        stall_ok = 32'd0;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("stall_hold", stall_ok, 32'd1);
    complete("stall", 32'h0A0B0C0D, 117);
    repeat (3) @(negedge clk);
    check("no_queued_vector", {30'd0, busy, bus.mac_clr}, 32'd0);

    // asynchronous reset in the middle of an inference
    start_inference("abort", 32'h01020304);
    repeat (39) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_ctrl", {19'd0, bus.in_ready, bus.out_valid, busy, bus.mac_clr, bus.mac_en,
                         bus.w_addr, layer_idx, neuron_idx}, 32'd0);
    check("abort_mac_a", {24'd0, bus.mac_a}, 32'd0);
    check("abort_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    start_inference("rerun", 32'h05060708);
    wait_out("rerun");
    complete("rerun", 32'h05060708, 97);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
